// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter slice.
// Holds the default width and the Gray encode/decode/popcount functions.
// Functions work on MAX_WIDTH-bit vectors; callers zero-extend narrower values
// and truncate the result, which is exact because the upper bits stay zero.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-reflected Gray encoder.
// Ports:
//   bin  - binary input (WIDTH)
//   gray - Gray-coded output (WIDTH)
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Gray-code up/down counter with parallel load, terminal-count flag and a
// sticky single-bit-step monitor on the Gray output.
// Optional build macro: GRAY_CNT_SATURATE_EN (saturate at the ends instead of
// wrapping; the monitor ignores the resulting held cycles).
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   en       - count enable, one step per cycle
//   up       - 1 = increment, 0 = decrement (binary sense)
//   load     - synchronous parallel load, overrides en
//   load_val - binary value to load (WIDTH)
//   gray     - registered Gray count (WIDTH)
//   bin      - registered binary count (WIDTH)
//   tc       - terminal count, combinational from state and inputs
//   step_err - sticky: a counting update changed other than one Gray bit
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             step_err
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] bin_q, gray_q, bin_next, gray_next;
    logic             err_q;
    logic             at_top, at_bot, sat_hold, upd, step_bad;

    assign at_top = (bin_q == ALL_ONES);
    assign at_bot = (bin_q == '0);

`ifdef GRAY_CNT_SATURATE_EN
    // Counting past an end is suppressed; the counter simply holds.
    assign sat_hold = en & ~load & (up ? at_top : at_bot);
`else
    assign sat_hold = 1'b0;
`endif

    always_comb begin
        bin_next = bin_q;
        if (load) begin
            bin_next = load_val;
        end else if (en && !sat_hold) begin
            bin_next = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        end
    end

    // Gray register is fed from the encoded next binary value so both
    // registers always agree and neither has an input-to-output path.
    bin_to_gray #(.WIDTH(WIDTH)) u_b2g (
        .bin  (bin_next),
        .gray (gray_next)
    );

    assign upd      = en & ~load & ~sat_hold;
    assign step_bad = upd && (popcount(MAX_WIDTH'(gray_q ^ gray_next)) != 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            err_q  <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            if (step_bad) err_q <= 1'b1;
        end
    end

    assign tc       = en & ~load & (up ? at_top : at_bot);
    assign gray     = gray_q;
    assign bin      = bin_q;
    assign step_err = err_q;

endmodule
